// File: rtl/sysid_check_pkg.sv
// ============================================================================
// sysid_check_pkg : shared types and constants for the sysid check master
// Rev 1.0
// ============================================================================
`default_nettype none

package sysid_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ID  = 2'd1,
        RD_TS  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd28;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1718117590;

endpackage

`default_nettype wire

// File: rtl/sysid_check_master.sv
// ============================================================================
// sysid_check_master : Avalon-MM master reading sysid ID/timestamp and
// comparing against build constants. Optional: SYSID_CHECK_AUTOSTART_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module sysid_check_master
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timed_out,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] stall_cnt;
    logic             start_req;
    logic             in_read;
    logic             accept;
    logic             expired;

`ifdef SYSID_CHECK_AUTOSTART_EN
    logic auto_start;

    // One-shot: high only in the first cycle after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) auto_start <= 1'b1;
        else          auto_start <= 1'b0;
    end

    assign start_req = start | auto_start;
`else
    assign start_req = start;
`endif

    assign in_read = (state == RD_ID) || (state == RD_TS);
    assign accept  = in_read && !avm_waitrequest;
    assign expired = TIMEOUT_EN && in_read && avm_waitrequest && (stall_cnt == TIMEOUT_VAL);

    // Bus outputs decode straight from state so reset drops them asynchronously.
    assign avm_read    = in_read;
    assign avm_address = (state == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    assign busy        = in_read;
    assign done        = (state == FINISH);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_req) state_next = RD_ID;
            RD_ID: begin
                if (accept)       state_next = RD_TS;
                else if (expired) state_next = FINISH;
            end
            RD_TS:   if (accept || expired) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Clears on every state change (hence on entry to each read), saturates.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (state_next != state) begin
            stall_cnt <= '0;
        end else if (in_read && avm_waitrequest && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            timed_out <= 1'b0;
            id_value  <= '0;
            ts_value  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_req) begin
                        id_ok     <= 1'b0;
                        ts_ok     <= 1'b0;
                        timed_out <= 1'b0;
                        id_value  <= '0;
                        ts_value  <= '0;
                    end
                end
                RD_ID: begin
                    if (accept) begin
                        id_value <= avm_readdata;
                    end else if (expired) begin
                        timed_out <= 1'b1;
                        id_ok     <= 1'b0;
                        ts_ok     <= 1'b0;
                    end
                end
                RD_TS: begin
                    if (accept) begin
                        ts_value <= avm_readdata;
                        id_ok    <= (id_value == EXPECTED_ID);
                        ts_ok    <= (avm_readdata == EXPECTED_TS);
                    end else if (expired) begin
                        timed_out <= 1'b1;
                        id_ok     <= 1'b0;
                        ts_ok     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sysid_check_master.sv
// ============================================================================
// tb_sysid_check_master : randomized self-checking bench with sysid slave model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sysid_check_master;

    localparam int          T     = 4;
    localparam logic [31:0] EID   = 32'd28;
    localparam logic [31:0] ETS   = 32'd1718117590;
    localparam int          STUCK = 1000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_address;
    logic        avm_read;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timed_out;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    sysid_check_master #(
        .EXPECTED_ID    (EID),
        .EXPECTED_TS    (ETS),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (8)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .busy            (busy),
        .done            (done),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timed_out       (timed_out),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    endtask

    function automatic logic [31:0] all_outputs();
        return {25'd0, avm_address, avm_read, busy, done, id_ok, ts_ok, timed_out};
    endfunction

    // Called at a negedge; returns at a negedge. A read with w stall cycles
    // aborts when w exceeds T, occupying T+1 bus cycles.
    task automatic run_check(input logic [31:0] id_word, input logic [31:0] ts_word,
                             input int id_wait, input int ts_wait, input bit use_start,
                             input bit poke_busy, input bit poke_finish);
        int  c0 = 0, c1 = 0, edges = 0, wait_left = 0, done_edge = -1, order_err = 0, cur = -1;
        bit  to_id, to_ts, to;
        int  exp_c0, exp_c1;
        logic [31:0] exp_idv, exp_tsv;

        to_id   = (id_wait > T);
        to_ts   = !to_id && (ts_wait > T);
        to      = to_id || to_ts;
        exp_c0  = to_id ? T + 1 : id_wait + 1;
        exp_c1  = to_id ? 0 : (to_ts ? T + 1 : ts_wait + 1);
        exp_idv = to_id ? 32'd0 : id_word;
        exp_tsv = to ? 32'd0 : ts_word;

        start = use_start;
        while (edges < 200 && done_edge < 0) begin
            if (avm_read) begin
                if (int'(avm_address) != cur) begin
                    if (int'(avm_address) < cur) order_err++;
                    cur       = int'(avm_address);
                    wait_left = (cur == 1) ? ts_wait : id_wait;
                end
                if (cur == 0) c0++; else c1++;
                if (wait_left > 0) begin
                    avm_waitrequest = 1'b1;
                    avm_readdata    = $urandom;
                    wait_left--;
                end else begin
                    avm_waitrequest = 1'b0;
                    avm_readdata    = (cur == 1) ? ts_word : id_word;
                end
            end else begin
                avm_waitrequest = 1'($urandom_range(0, 1));
                avm_readdata    = $urandom;
            end
            if (poke_busy && edges == 2) start = 1'b1;
            @(posedge clock);
            edges++;
            @(negedge clock);
            start = 1'b0;
            if (done) done_edge = edges;
        end

        if (done_edge < 0) begin
            check("done_seen", 32'd0, 32'd1);
            return;
        end
        check("done_latency", done_edge, 1 + exp_c0 + exp_c1);
        check("id_ok",        id_ok, (!to && id_word == EID) ? 32'd1 : 32'd0);
        check("ts_ok",        ts_ok, (!to && ts_word == ETS) ? 32'd1 : 32'd0);
        check("timed_out",    timed_out, to ? 32'd1 : 32'd0);
        check("id_value",     id_value, exp_idv);
        check("ts_value",     ts_value, exp_tsv);
        check("busy_in_fin",  busy, 32'd0);
        check("read_in_fin",  avm_read, 32'd0);
        check("id_rd_cycles", c0, exp_c0);
        check("ts_rd_cycles", c1, exp_c1);
        check("addr_order",   order_err, 32'd0);

        start = poke_finish;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check("done_once",    done, 32'd0);
        check("idle_after",   busy, 32'd0);
        check("hold_id_ok",   id_ok, (!to && id_word == EID) ? 32'd1 : 32'd0);
        check("hold_id_val",  id_value, exp_idv);
        @(posedge clock);
        @(negedge clock);
        check("fin_start_ign", busy, 32'd0);
    endtask

    task automatic after_release();
`ifdef SYSID_CHECK_AUTOSTART_EN
        run_check(EID, ETS, 0, 0, 1'b0, 1'b0, 1'b0);
`else
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("no_autostart", busy, 32'd0);
`endif
    endtask

    task automatic reset_mid_ts();
        start           = 1'b1;
        avm_waitrequest = 1'b0;
        avm_readdata    = EID;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("pre_rst_addr", avm_address, 32'd1);
        check("pre_rst_read", avm_read, 32'd1);
        avm_waitrequest = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_outs", all_outputs(), 32'd0);
        check("rst_id_value",   id_value, 32'd0);
        check("rst_ts_value",   ts_value, 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_no_done",    all_outputs(), 32'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        int iw, tw;
        logic [31:0] idw, tsw;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_outs",     all_outputs(), 32'd0);
        check("reset_id_value", id_value, 32'd0);
        check("reset_ts_value", ts_value, 32'd0);
        reset_n = 1'b1;
        after_release();

        run_check(EID,   ETS, 0,     0,     1'b1, 1'b0, 1'b0);
        run_check(32'd29, ETS, 0,    0,     1'b1, 1'b1, 1'b1);
        run_check(EID,   ETS, 3,     3,     1'b1, 1'b1, 1'b0);
        run_check(EID,   ETS, STUCK, 0,     1'b1, 1'b0, 1'b1);
        run_check(EID,   ETS, 1,     STUCK, 1'b1, 1'b1, 1'b0);
        run_check(EID,   32'd5, 2,   0,     1'b1, 1'b0, 1'b0);

        reset_mid_ts();
        after_release();
        run_check(EID, ETS, 0, 0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            iw  = ($urandom_range(0, 7) == 0) ? STUCK : int'($urandom_range(0, T - 1));
            tw  = ($urandom_range(0, 7) == 0) ? STUCK : int'($urandom_range(0, T - 1));
            idw = ($urandom_range(0, 3) == 0) ? $urandom : EID;
            tsw = ($urandom_range(0, 3) == 0) ? $urandom : ETS;
            repeat ($urandom_range(0, 2)) @(negedge clock);
            run_check(idw, tsw, iw, tw, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
